wvb_dpram_writer: RTL and testbench

//  Producer side of the direct-readout DPRAM handshake. Pops one waveform (header + samples) from the

---
 rtl/wvb_dpram_writer_pkg.sv | 25 ++
 rtl/wvb_dpram_writer_if.sv | 27 ++
 rtl/wvb_dpram_writer.sv | 159 +++++++++++++++
 tb/tb_wvb_dpram_writer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wvb_dpram_writer_pkg.sv
// Shared definitions for the waveform-buffer -> readout DPRAM writer:
// header field layout, header word count and FSM state encoding.
package wvb_dpram_writer_pkg;

  localparam int HDR_WORDS = 2;
  localparam int TS_LSB    = 16;
  localparam int NW_MSB    = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR_POP   = 3'd1,
    ST_HDR_LAT   = 3'd2,
    ST_DATA      = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_PUBLISH   = 3'd5,
    ST_WAIT_ACK  = 3'd6,
    ST_WAIT_DONE = 3'd7
  } state_t;

  // Packet length is reported in 16-bit units; every DPRAM word is two of them.
  function automatic logic [15:0] pkt_len16(input logic [15:0] words);
    return {words[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/wvb_dpram_writer_if.sv
// Readout DPRAM port: write side plus the run/busy publish handshake toward xdom.
interface wvb_dpram_writer_if #(
  parameter int ADDR_W = 10
);

  logic              wren;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       data;
  logic              run;
  logic [15:0]       len;
  logic              busy;

  // Handshake: run is a one-cycle strobe with len valid in that cycle (len then
  // holds until the next run). The consumer acknowledges by raising busy and
  // releases the DPRAM by dropping it; the writer touches the DPRAM again only
  // after it has seen busy rise and then fall.
  modport master (
    output wren, wr_addr, data, run, len,
    input  busy
  );

  modport slave (
    input  wren, wr_addr, data, run, len,
    output busy
  );

endinterface

// File: rtl/wvb_dpram_writer.sv
// Pops one waveform (header + samples) from the waveform buffer, writes it as a
// packet into the readout DPRAM and publishes it to the register-side consumer.
module wvb_dpram_writer
  import wvb_dpram_writer_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TS_W    = 48,
  parameter int NW_W    = 16,
  parameter int MAX_WDS = (2 ** ADDR_W) - HDR_WORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 dpram_mode,
  input  logic                 hdr_empty,
  input  logic [TS_W+NW_W-1:0] hdr_data,
  output logic                 hdr_rdreq,
  input  logic [31:0]          wvb_data,
  output logic                 wvb_rdreq,
  output logic                 trunc_err,
  output logic                 idle,
  output state_t               state_dbg,
  wvb_dpram_writer_if.master   dpram
);

  localparam logic [NW_W-1:0] MAX_LIM = NW_W'(MAX_WDS);

  state_t            state;
  logic              mode_q;
  logic [NW_W-1:0]   n_wds_q;
  logic [NW_W-1:0]   rd_cnt;
  logic [NW_W-1:0]   wr_cnt;
  logic [31:0]       hdr1_q;
  logic              hdr1_pend;
  logic              wr_samp_q;
  logic              run_q;
  logic [15:0]       len_q;

  logic [NW_W-1:0]   lim;
  logic [NW_W-1:0]   rd_nxt;
  logic [NW_W-1:0]   wr_nxt;
  logic              wr_hdr0;
  logic              wr_hdr1;
  logic              wren;
  logic [31:0]       wr_data;

  assign lim     = (n_wds_q > MAX_LIM) ? MAX_LIM : n_wds_q;
  assign rd_nxt  = rd_cnt + NW_W'(1);
  assign wr_hdr0 = mode_q && (state == ST_HDR_LAT);
  assign wr_hdr1 = mode_q && hdr1_pend;
  assign wren    = wr_hdr0 || wr_hdr1 || wr_samp_q;
  assign wr_nxt  = wren ? (wr_cnt + NW_W'(1)) : wr_cnt;

  // Samples go out the cycle the FIFO presents them, so the data path is a mux
  // rather than a register; only the strobe is delayed to line up with it.
  always_comb begin
    wr_data = '0;
    if (wr_samp_q)    wr_data = wvb_data;
    else if (wr_hdr0) wr_data = hdr_data[TS_W+NW_W-1 -: 32];
    else if (wr_hdr1) wr_data = hdr1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= 1'b0;
      n_wds_q   <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      hdr1_q    <= '0;
      hdr1_pend <= 1'b0;
      wr_samp_q <= 1'b0;
      run_q     <= 1'b0;
      len_q     <= '0;
      hdr_rdreq <= 1'b0;
      wvb_rdreq <= 1'b0;
      trunc_err <= 1'b0;
    end else begin
      hdr_rdreq <= 1'b0;
      trunc_err <= 1'b0;
      run_q     <= 1'b0;
      hdr1_pend <= 1'b0;
      wr_samp_q <= mode_q && (state == ST_DATA) && wvb_rdreq;
      wr_cnt    <= wr_nxt;

      case (state)
        ST_IDLE: begin
          wr_cnt <= '0;
          rd_cnt <= '0;
          if (en && !hdr_empty && !dpram.busy) begin
            hdr_rdreq <= 1'b1;
            state     <= ST_HDR_POP;
          end
        end
        ST_HDR_POP: begin
          mode_q <= dpram_mode;
          state  <= ST_HDR_LAT;
        end
        ST_HDR_LAT: begin
          n_wds_q   <= hdr_data[NW_MSB:0];
          hdr1_q    <= hdr_data[NW_W+TS_LSB-1:0];
          hdr1_pend <= 1'b1;
          rd_cnt    <= '0;
          wvb_rdreq <= (hdr_data[NW_MSB:0] != '0);
          state     <= ST_DATA;
        end
        ST_DATA: begin
          if (wvb_rdreq) begin
            rd_cnt <= rd_nxt;
            if (rd_nxt >= lim) begin
              // Oversized waveform: keep popping so the data FIFO stays aligned.
              if (n_wds_q > MAX_LIM) begin
                trunc_err <= 1'b1;
                state     <= ST_DRAIN;
              end else begin
                wvb_rdreq <= 1'b0;
              end
            end
          end else if (mode_q) begin
            run_q <= 1'b1;
            len_q <= pkt_len16(16'(wr_nxt));
            state <= ST_PUBLISH;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (wvb_rdreq) begin
            rd_cnt <= rd_nxt;
            if (rd_nxt >= n_wds_q) wvb_rdreq <= 1'b0;
          end else if (mode_q) begin
            run_q <= 1'b1;
            len_q <= pkt_len16(16'(wr_nxt));
            state <= ST_PUBLISH;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_PUBLISH: state <= ST_WAIT_ACK;
        ST_WAIT_ACK: begin
          if (dpram.busy) state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (!dpram.busy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dpram.wren    = wren;
  assign dpram.wr_addr = wr_cnt[ADDR_W-1:0];
  assign dpram.data    = wr_data;
  assign dpram.run     = run_q;
  assign dpram.len     = len_q;
  assign idle          = (state == ST_IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_wvb_dpram_writer.sv
// Directed bench for wvb_dpram_writer: FIFO models, DPRAM write monitor and
// one task per scenario with hand-computed expectations.
module tb_wvb_dpram_writer;
  import wvb_dpram_writer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        dpram_mode = 1'b1;
  logic        hdr_empty = 1'b1;
  logic [63:0] hdr_data = '0;
  logic        hdr_rdreq;
  logic [31:0] wvb_data = '0;
  logic        wvb_rdreq;
  logic        trunc_err;
  logic        idle;
  state_t      state_dbg;

  wvb_dpram_writer_if #(.ADDR_W(10)) dpram_if ();

  wvb_dpram_writer #(.ADDR_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .dpram_mode(dpram_mode),
    .hdr_empty (hdr_empty),
    .hdr_data  (hdr_data),
    .hdr_rdreq (hdr_rdreq),
    .wvb_data  (wvb_data),
    .wvb_rdreq (wvb_rdreq),
    .trunc_err (trunc_err),
    .idle      (idle),
    .state_dbg (state_dbg),
    .dpram     (dpram_if)
  );

  // ---------------- FIFO models (show-ahead by one cycle) ----------------
  logic [63:0] hdr_fifo[$];
  logic [31:0] wvb_fifo[$];

  always @(posedge clk) begin
    if (hdr_rdreq === 1'b1 && hdr_fifo.size() > 0) hdr_data <= hdr_fifo.pop_front();
    if (wvb_rdreq === 1'b1) begin
      if (wvb_fifo.size() > 0) wvb_data <= wvb_fifo.pop_front();
      else                     wvb_data <= 32'hDEAD_BEEF;
    end
    hdr_empty <= (hdr_fifo.size() == 0);
  end

  // ---------------- monitor ----------------
  int          cyc = 0;
  int          hdr_rd_cnt = 0, wvb_rd_cnt = 0, run_cnt = 0, trunc_cnt = 0;
  int          run_cyc = 0, last_hdr_cyc = 0, busy_fall_cyc = 0;
  logic [15:0] last_len = '0;
  logic        prev_busy = 1'b0;
  logic [41:0] act_q[$];

  always @(negedge clk) begin
    cyc++;
    if (hdr_rdreq === 1'b1) begin hdr_rd_cnt++; last_hdr_cyc = cyc; end
    if (wvb_rdreq === 1'b1) wvb_rd_cnt++;
    if (dpram_if.wren === 1'b1) act_q.push_back({dpram_if.wr_addr, dpram_if.data});
    if (dpram_if.run === 1'b1) begin run_cnt++; run_cyc = cyc; last_len = dpram_if.len; end
    if (trunc_err === 1'b1) trunc_cnt++;
    if (prev_busy && !dpram_if.busy) busy_fall_cyc = cyc;
    prev_busy = dpram_if.busy;
  end

  // ---------------- scoreboard state ----------------
  logic [41:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_hdr(input logic [47:0] ts, input int n);
    hdr_fifo.push_back({ts, 16'(n)});
  endtask

  task automatic push_words(input logic [31:0] base, input logic [31:0] step, input int n);
    for (int i = 0; i < n; i++) wvb_fifo.push_back(base + step * 32'(i));
  endtask

  task automatic wait_run(input int base, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (run_cnt > base) seen = 1'b1;
    end
  endtask

  task automatic consumer(input int hold);
    dpram_if.busy = 1'b1;
    repeat (hold) tick();
    dpram_if.busy = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (idle === 1'b1) ok = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); end
    n_checks++; if ({hdr_rdreq, wvb_rdreq, dpram_if.wren, dpram_if.run, trunc_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 00000", {hdr_rdreq, wvb_rdreq, dpram_if.wren, dpram_if.run, trunc_err});
    end
    n_checks++; if (dpram_if.len !== 16'd0) begin n_fail++; $display("FAIL reset_len: got %0d want 0", dpram_if.len); end
    n_checks++; if (dpram_if.wr_addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", dpram_if.wr_addr); end
  endtask

  task automatic test_basic();
    bit seen, ok;
    int r0, a0;
    r0 = run_cnt; a0 = act_q.size();
    dpram_mode = 1'b1; en = 1'b1;
    push_hdr(48'h0123_4567_89AB, 3);
    push_words(32'h11, 32'h11, 3);
    wait_run(r0, 200, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL basic_run: no dpram_run within 200 cycles"); end
    exp_q.delete();
    exp_q.push_back({10'd0, 32'h0123_4567});
    exp_q.push_back({10'd1, 32'h89AB_0003});
    exp_q.push_back({10'd2, 32'h11});
    exp_q.push_back({10'd3, 32'h22});
    exp_q.push_back({10'd4, 32'h33});
    n_checks++; if (act_q.size() - a0 != exp_q.size()) begin
      n_fail++; $display("FAIL basic_nwrites: got %0d want %0d", act_q.size() - a0, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && a0 + k < act_q.size(); k++) begin
      n_checks++; if (act_q[a0+k] !== exp_q[k]) begin
        n_fail++; $display("FAIL basic_write%0d: got %h want %h", k, act_q[a0+k], exp_q[k]);
      end
    end
    n_checks++; if (last_len !== 16'd10) begin n_fail++; $display("FAIL basic_len: got %0d want 10", last_len); end
    // HDR_POP is one cycle after IDLE; IDLE->PUBLISH is N+4.
    n_checks++; if (run_cyc - last_hdr_cyc != 6) begin
      n_fail++; $display("FAIL basic_latency: got %0d want 6", run_cyc - last_hdr_cyc);
    end
    consumer(3);
    wait_idle(50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_idle: not idle after handshake"); end
  endtask

  task automatic test_zero_len();
    bit seen, ok;
    int r0, a0, w0;
    r0 = run_cnt; a0 = act_q.size(); w0 = wvb_rd_cnt;
    push_hdr(48'hAAAA_BBBB_CCCC, 0);
    wait_run(r0, 200, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL zero_run: no dpram_run within 200 cycles"); end
    exp_q.delete();
    exp_q.push_back({10'd0, 32'hAAAA_BBBB});
    exp_q.push_back({10'd1, 32'hCCCC_0000});
    n_checks++; if (act_q.size() - a0 != 2) begin n_fail++; $display("FAIL zero_nwrites: got %0d want 2", act_q.size() - a0); end
    for (int k = 0; k < exp_q.size() && a0 + k < act_q.size(); k++) begin
      n_checks++; if (act_q[a0+k] !== exp_q[k]) begin
        n_fail++; $display("FAIL zero_write%0d: got %h want %h", k, act_q[a0+k], exp_q[k]);
      end
    end
    n_checks++; if (wvb_rd_cnt - w0 != 0) begin n_fail++; $display("FAIL zero_rdreq: got %0d want 0", wvb_rd_cnt - w0); end
    n_checks++; if (last_len !== 16'd4) begin n_fail++; $display("FAIL zero_len: got %0d want 4", last_len); end
    n_checks++; if (run_cyc - last_hdr_cyc != 3) begin
      n_fail++; $display("FAIL zero_latency: got %0d want 3", run_cyc - last_hdr_cyc);
    end
    consumer(2);
    wait_idle(50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_idle: not idle after handshake"); end
  endtask

  task automatic test_truncate();
    bit seen, ok;
    int r0, a0, w0, t0;
    r0 = run_cnt; a0 = act_q.size(); w0 = wvb_rd_cnt; t0 = trunc_cnt;
    push_hdr(48'h0000_0000_0042, 1030);
    push_words(32'h1000, 32'h1, 1030);
    wait_run(r0, 2000, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL trunc_run: no dpram_run within 2000 cycles"); end
    exp_q.delete();
    exp_q.push_back({10'd0, 32'h0000_0000});
    exp_q.push_back({10'd1, 32'h0042_0406});
    for (int i = 0; i < 1022; i++) exp_q.push_back({10'(i + 2), 32'h1000 + 32'(i)});
    n_checks++; if (act_q.size() - a0 != 1024) begin n_fail++; $display("FAIL trunc_nwrites: got %0d want 1024", act_q.size() - a0); end
    for (int k = 0; k < exp_q.size() && a0 + k < act_q.size(); k++) begin
      n_checks++; if (act_q[a0+k] !== exp_q[k]) begin
        n_fail++; $display("FAIL trunc_write%0d: got %h want %h", k, act_q[a0+k], exp_q[k]);
      end
    end
    n_checks++; if (wvb_rd_cnt - w0 != 1030) begin n_fail++; $display("FAIL trunc_rdreq: got %0d want 1030", wvb_rd_cnt - w0); end
    n_checks++; if (trunc_cnt - t0 != 1) begin n_fail++; $display("FAIL trunc_pulse: got %0d want 1", trunc_cnt - t0); end
    n_checks++; if (last_len !== 16'd2048) begin n_fail++; $display("FAIL trunc_len: got %0d want 2048", last_len); end
    n_checks++; if (wvb_fifo.size() != 0) begin n_fail++; $display("FAIL trunc_drain: got %0d left want 0", wvb_fifo.size()); end
    consumer(2);
    wait_idle(50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL trunc_idle: not idle after handshake"); end
  endtask

  task automatic test_back_to_back();
    bit seen, ok;
    int r0, h0, a0, a1;
    r0 = run_cnt;
    push_hdr(48'h1111_2222_3333, 2);
    push_words(32'hA0, 32'h1, 2);
    push_hdr(48'h4444_5555_6666, 2);
    push_words(32'hB0, 32'h1, 2);
    wait_run(r0, 200, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL b2b_run1: no first dpram_run"); end
    dpram_if.busy = 1'b1;
    h0 = hdr_rd_cnt; a0 = act_q.size();
    repeat (50) tick();
    n_checks++; if (hdr_rd_cnt != h0) begin n_fail++; $display("FAIL b2b_hold_hdr: got %0d pops want 0", hdr_rd_cnt - h0); end
    n_checks++; if (act_q.size() != a0) begin n_fail++; $display("FAIL b2b_hold_wr: got %0d writes want 0", act_q.size() - a0); end
    a1 = act_q.size();
    dpram_if.busy = 1'b0;
    wait_run(r0 + 1, 200, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL b2b_run2: no second dpram_run"); end
    n_checks++; if (last_hdr_cyc <= busy_fall_cyc) begin
      n_fail++; $display("FAIL b2b_order: hdr_rdreq cycle %0d not after busy fall %0d", last_hdr_cyc, busy_fall_cyc);
    end
    exp_q.delete();
    exp_q.push_back({10'd0, 32'h4444_5555});
    exp_q.push_back({10'd1, 32'h6666_0002});
    exp_q.push_back({10'd2, 32'hB0});
    exp_q.push_back({10'd3, 32'hB1});
    n_checks++; if (act_q.size() - a1 != 4) begin n_fail++; $display("FAIL b2b_nwrites: got %0d want 4", act_q.size() - a1); end
    for (int k = 0; k < exp_q.size() && a1 + k < act_q.size(); k++) begin
      n_checks++; if (act_q[a1+k] !== exp_q[k]) begin
        n_fail++; $display("FAIL b2b_write%0d: got %h want %h", k, act_q[a1+k], exp_q[k]);
      end
    end
    n_checks++; if (last_len !== 16'd8) begin n_fail++; $display("FAIL b2b_len: got %0d want 8", last_len); end
    consumer(2);
    wait_idle(50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_idle: not idle after handshake"); end
  endtask

  task automatic test_discard();
    int r0, a0, w0;
    r0 = run_cnt; a0 = act_q.size(); w0 = wvb_rd_cnt;
    dpram_mode = 1'b0;
    push_hdr(48'h7777_8888_9999, 5);
    push_words(32'hC0, 32'h1, 5);
    repeat (30) tick();
    dpram_mode = 1'b1;
    n_checks++; if (wvb_rd_cnt - w0 != 5) begin n_fail++; $display("FAIL discard_rdreq: got %0d want 5", wvb_rd_cnt - w0); end
    n_checks++; if (act_q.size() != a0) begin n_fail++; $display("FAIL discard_wren: got %0d writes want 0", act_q.size() - a0); end
    n_checks++; if (run_cnt != r0) begin n_fail++; $display("FAIL discard_run: got %0d runs want 0", run_cnt - r0); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL discard_idle: got %b want 1", idle); end
    n_checks++; if (wvb_fifo.size() != 0) begin n_fail++; $display("FAIL discard_align: got %0d left want 0", wvb_fifo.size()); end
  endtask

  task automatic test_reset_mid();
    int w0;
    bit hit;
    w0 = wvb_rd_cnt; hit = 1'b0;
    push_hdr(48'h0BAD_0BAD_0BAD, 100);
    push_words(32'hD00, 32'h1, 100);
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      if (wvb_rd_cnt - w0 >= 10) hit = 1'b1;
    end
    n_checks++; if (!hit || state_dbg !== ST_DATA) begin
      n_fail++; $display("FAIL rstmid_reach: reached=%0b state=%0d want state %0d", hit, state_dbg, ST_DATA);
    end
    en = 1'b0;
    rst_n = 1'b0;
    tick();
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle: got %b want 1", idle); end
    n_checks++; if ({hdr_rdreq, wvb_rdreq, dpram_if.wren, dpram_if.run, trunc_err} !== 5'b0) begin
      n_fail++; $display("FAIL rstmid_strobes: got %b want 00000", {hdr_rdreq, wvb_rdreq, dpram_if.wren, dpram_if.run, trunc_err});
    end
    n_checks++; if (dpram_if.len !== 16'd0) begin n_fail++; $display("FAIL rstmid_len: got %0d want 0", dpram_if.len); end
    rst_n = 1'b1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    dpram_if.busy = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_zero_len();
    test_truncate();
    test_back_to_back();
    test_discard();
    test_reset_mid();
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
